// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for a 5-stage RV32I core: decodes once in ID, carries the
// control bundle through ID/EX, EX/MA and MA/WB, and resolves load-use stalls and redirects.
module pipe_ctrl_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_inst,
    input  logic              id_valid,
    input  logic              stall_ext,
    input  logic              ex_b_cmp,
    output logic [3:0]        id_imm_sel,
    output logic              id_illegal,
    output logic              hazard_stall,
    output logic              ex_A_sel,
    output logic              ex_B_sel,
    output logic [4:0]        ex_alu_ctl,
    output logic [1:0]        pc_sel,
    output logic              flush,
    output logic [3:0]        ma_dm_ctl,
    output logic [2:0]        ma_trim_ctl,
    output logic [1:0]        ma_din_sel,
    output logic              wb_reg_wrt,
    output logic [REG_AW-1:0] wb_rd
);

    typedef struct packed {
        logic              reg_wrt;
        logic [REG_AW-1:0] rd;
    } wb_t;

    typedef struct packed {
        logic [3:0] dm_ctl;
        logic [2:0] trim_ctl;
        logic [1:0] din_sel;
        wb_t        wb;
    } ma_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] alu_ctl;
        logic       a_sel;
        logic       b_sel;
        logic       is_load;
        logic       is_jump;
        logic       is_branch;
        ma_t        ma;
    } ex_t;

    localparam logic [4:0] AluAdd  = 5'b00001;
    localparam logic [4:0] AluSlt  = 5'b00010;
    localparam logic [4:0] AluSltu = 5'b00011;
    localparam logic [4:0] AluAnd  = 5'b00100;
    localparam logic [4:0] AluOr   = 5'b00101;
    localparam logic [4:0] AluXor  = 5'b00110;
    localparam logic [4:0] AluSll  = 5'b00111;
    localparam logic [4:0] AluSrl  = 5'b01000;
    localparam logic [4:0] AluSub  = 5'b01001;
    localparam logic [4:0] AluSra  = 5'b01010;
    localparam logic [4:0] AluLui  = 5'b10001;
    localparam logic [4:0] AluAddu = 5'b10010;
    localparam logic [4:0] AluMul  = 5'b10011;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic              illegal, uses_rs1, uses_rs2, writes;
    logic              raw_hazard;
    ex_t               dec;
    ex_t               id_ex_d, id_ex_q;
    ma_t               ex_ma_d, ex_ma_q;
    wb_t               ma_wb_d, ma_wb_q;

    assign opcode = id_inst[6:0];
    assign funct3 = id_inst[14:12];
    assign funct7 = id_inst[31:25];
    assign rd     = REG_AW'(id_inst[11:7]);
    assign rs1    = REG_AW'(id_inst[19:15]);
    assign rs2    = REG_AW'(id_inst[24:20]);

    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        id_imm_sel = 4'b0000;
        illegal    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        writes     = 1'b0;
        unique case (opcode)
            7'b0110111: begin  // LUI
                id_imm_sel = 4'b0101;
                {dec.a_sel, dec.b_sel, dec.alu_ctl} = {2'b01, AluLui};
                dec.ma.din_sel = 2'b10;
                writes = 1'b1;
            end
            7'b0010111: begin  // AUIPC
                id_imm_sel = 4'b0101;
                {dec.a_sel, dec.b_sel, dec.alu_ctl} = {2'b01, AluAdd};
                dec.ma.din_sel = 2'b10;
                writes = 1'b1;
            end
            7'b1101111: begin  // JAL
                id_imm_sel = 4'b0110;
                {dec.a_sel, dec.b_sel, dec.alu_ctl} = {2'b01, AluAdd};
                dec.ma.din_sel = 2'b01;
                dec.is_jump = 1'b1;
                writes = 1'b1;
            end
            7'b1100111: begin  // JALR
                id_imm_sel = 4'b0001;
                {dec.a_sel, dec.b_sel, dec.alu_ctl} = {2'b11, AluAdd};
                dec.ma.din_sel = 2'b01;
                dec.is_jump = 1'b1;
                uses_rs1 = 1'b1;
                writes = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            7'b1100011: begin  // branches compare rs1 against rs2
                id_imm_sel = 4'b0100;
                {dec.a_sel, dec.b_sel} = 2'b10;
                dec.is_branch = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                unique case (funct3)
                    3'b000:  dec.alu_ctl = 5'b01011;
                    3'b001:  dec.alu_ctl = 5'b01100;
                    3'b100:  dec.alu_ctl = 5'b01101;
                    3'b101:  dec.alu_ctl = 5'b01111;
                    3'b110:  dec.alu_ctl = 5'b01110;
                    3'b111:  dec.alu_ctl = 5'b10000;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0000011: begin  // loads
                id_imm_sel = 4'b0001;
                {dec.a_sel, dec.b_sel, dec.alu_ctl} = {2'b11, AluAdd};
                dec.ma.din_sel = 2'b11;
                dec.is_load = 1'b1;
                uses_rs1 = 1'b1;
                writes = 1'b1;
                unique case (funct3)
                    3'b000:  dec.ma.trim_ctl = 3'b010;
                    3'b001:  dec.ma.trim_ctl = 3'b001;
                    3'b010:  dec.ma.trim_ctl = 3'b000;
                    3'b100:  {dec.alu_ctl, dec.ma.trim_ctl} = {AluAddu, 3'b011};
                    3'b101:  {dec.alu_ctl, dec.ma.trim_ctl} = {AluAddu, 3'b100};
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin  // stores
                id_imm_sel = 4'b0011;
                {dec.a_sel, dec.b_sel, dec.alu_ctl} = {2'b11, AluAdd};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                unique case (funct3)
                    3'b000:  dec.ma.dm_ctl = 4'b0001;
                    3'b001:  dec.ma.dm_ctl = 4'b0011;
                    3'b010:  dec.ma.dm_ctl = 4'b1111;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0010011: begin  // OP-IMM
                id_imm_sel = 4'b0001;
                {dec.a_sel, dec.b_sel} = 2'b11;
                dec.ma.din_sel = 2'b10;
                uses_rs1 = 1'b1;
                writes = 1'b1;
                unique case (funct3)
                    3'b000: dec.alu_ctl = AluAdd;
                    3'b010: dec.alu_ctl = AluSlt;
                    3'b011: {id_imm_sel, dec.alu_ctl} = {4'b1001, AluSltu};
                    3'b100: dec.alu_ctl = AluXor;
                    3'b110: dec.alu_ctl = AluOr;
                    3'b111: dec.alu_ctl = AluAnd;
                    3'b001: begin
                        id_imm_sel = 4'b0010;
                        dec.alu_ctl = AluSll;
                        illegal = (funct7 != 7'b0000000);
                    end
                    default: begin  // 101: SRLI / SRAI
                        id_imm_sel = 4'b0010;
                        if (funct7 == 7'b0000000)      dec.alu_ctl = AluSrl;
                        else if (funct7 == 7'b0100000) dec.alu_ctl = AluSra;
                        else                           illegal = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin  // OP
                {dec.a_sel, dec.b_sel} = 2'b10;
                dec.ma.din_sel = 2'b10;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                writes = 1'b1;
                if (funct7 == 7'b0000000) begin
                    unique case (funct3)
                        3'b000:  dec.alu_ctl = AluAdd;
                        3'b001:  dec.alu_ctl = AluSll;
                        3'b010:  dec.alu_ctl = AluSlt;
                        3'b011:  dec.alu_ctl = AluSltu;
                        3'b100:  dec.alu_ctl = AluXor;
                        3'b101:  dec.alu_ctl = AluSrl;
                        3'b110:  dec.alu_ctl = AluOr;
                        default: dec.alu_ctl = AluAnd;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_ctl = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_ctl = AluSra;
                end else if (funct7 == 7'b0000001 && ENABLE_M) begin
                    // M ops are numbered consecutively in funct3 order from MUL
                    dec.alu_ctl = AluMul + {2'b00, funct3};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        dec.ma.wb.reg_wrt = writes && (rd != '0);
        dec.ma.wb.rd      = dec.ma.wb.reg_wrt ? rd : '0;
    end

    assign id_illegal = id_valid & illegal;

    always_comb begin
        pc_sel = 2'b00;
        if (!stall_ext && id_ex_q.valid) begin
            if (id_ex_q.is_jump)                    pc_sel = 2'b10;
            else if (id_ex_q.is_branch && ex_b_cmp) pc_sel = 2'b01;
        end
    end

    assign flush = (pc_sel != 2'b00);

    assign raw_hazard = id_valid & id_ex_q.valid & id_ex_q.is_load & (id_ex_q.ma.wb.rd != '0) &
                        (((id_ex_q.ma.wb.rd == rs1) & uses_rs1) |
                         ((id_ex_q.ma.wb.rd == rs2) & uses_rs2));
    // A redirect kills the dependent instruction anyway, so the stall is dropped.
    assign hazard_stall = raw_hazard & ~flush;

    always_comb begin
        id_ex_d = id_ex_q;
        ex_ma_d = ex_ma_q;
        ma_wb_d = ma_wb_q;
        if (!stall_ext) begin
            id_ex_d = (hazard_stall | flush | !id_valid | id_illegal) ? '0 : dec;
            ex_ma_d = id_ex_q.ma;
            ma_wb_d = ex_ma_q.wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
            ex_ma_q <= '0;
            ma_wb_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
            ex_ma_q <= ex_ma_d;
            ma_wb_q <= ma_wb_d;
        end
    end

    assign ex_A_sel    = id_ex_q.a_sel;
    assign ex_B_sel    = id_ex_q.b_sel;
    assign ex_alu_ctl  = id_ex_q.alu_ctl;
    assign ma_dm_ctl   = ex_ma_q.dm_ctl;
    assign ma_trim_ctl = ex_ma_q.trim_ctl;
    assign ma_din_sel  = ex_ma_q.din_sel;
    assign wb_reg_wrt  = ma_wb_q.reg_wrt;
    assign wb_rd       = ma_wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected stage contents are queued as each ID
// instruction is driven and compared as they emerge in EX, MA and WB.
module tb_pipe_ctrl_unit;

    typedef struct packed {
        logic [4:0] alu;
        logic       a;
        logic       b;
        logic [1:0] din;
        logic [3:0] dm;
        logic [2:0] trim;
        logic       wrt;
        logic [4:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst;
    logic        id_valid, stall_ext, ex_b_cmp;
    logic [3:0]  id_imm_sel, id_imm_sel_0;
    logic        id_illegal, id_illegal_0;
    logic        hazard_stall, hazard_stall_0;
    logic        ex_A_sel, ex_A_sel_0, ex_B_sel, ex_B_sel_0;
    logic [4:0]  ex_alu_ctl, ex_alu_ctl_0;
    logic [1:0]  pc_sel, pc_sel_0;
    logic        flush, flush_0;
    logic [3:0]  ma_dm_ctl, ma_dm_ctl_0;
    logic [2:0]  ma_trim_ctl, ma_trim_ctl_0;
    logic [1:0]  ma_din_sel, ma_din_sel_0;
    logic        wb_reg_wrt, wb_reg_wrt_0;
    logic [4:0]  wb_rd, wb_rd_0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t exp_ex, exp_ma, exp_wb;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_M(1'b1)) u_dut (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .stall_ext(stall_ext),
        .ex_b_cmp(ex_b_cmp), .id_imm_sel(id_imm_sel), .id_illegal(id_illegal),
        .hazard_stall(hazard_stall), .ex_A_sel(ex_A_sel), .ex_B_sel(ex_B_sel),
        .ex_alu_ctl(ex_alu_ctl), .pc_sel(pc_sel), .flush(flush), .ma_dm_ctl(ma_dm_ctl),
        .ma_trim_ctl(ma_trim_ctl), .ma_din_sel(ma_din_sel), .wb_reg_wrt(wb_reg_wrt),
        .wb_rd(wb_rd)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_M(1'b0)) u_dut_nom (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .stall_ext(stall_ext),
        .ex_b_cmp(ex_b_cmp), .id_imm_sel(id_imm_sel_0), .id_illegal(id_illegal_0),
        .hazard_stall(hazard_stall_0), .ex_A_sel(ex_A_sel_0), .ex_B_sel(ex_B_sel_0),
        .ex_alu_ctl(ex_alu_ctl_0), .pc_sel(pc_sel_0), .flush(flush_0), .ma_dm_ctl(ma_dm_ctl_0),
        .ma_trim_ctl(ma_trim_ctl_0), .ma_din_sel(ma_din_sel_0), .wb_reg_wrt(wb_reg_wrt_0),
        .wb_rd(wb_rd_0)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ex_alu"}, {27'd0, ex_alu_ctl}, 32'd0);
        check_eq({tag, "_ex_ab"}, {30'd0, ex_A_sel, ex_B_sel}, 32'd0);
        check_eq({tag, "_ma"}, {23'd0, ma_dm_ctl, ma_trim_ctl, ma_din_sel}, 32'd0);
        check_eq({tag, "_wb"}, {26'd0, wb_reg_wrt, wb_rd}, 32'd0);
        check_eq({tag, "_ctl"}, {28'd0, pc_sel, flush, hazard_stall}, 32'd0);
    endtask

    // Entered at posedge+1; drives ID, checks combinational outputs, then registered ones.
    task automatic cyc(input logic [31:0] inst, input logic vld, input logic stl,
                       input logic bcmp, input exp_t rec, input logic [3:0] e_imm,
                       input logic e_ill, input logic e_ill0, input logic e_hz,
                       input logic [1:0] e_pc);
        id_inst = inst; id_valid = vld; stall_ext = stl; ex_b_cmp = bcmp;
        if (!stl) exp_q.push_back(rec);
        #3;
        if (vld) check_eq("imm_sel", {28'd0, id_imm_sel}, {28'd0, e_imm});
        check_eq("illegal_m1", {31'd0, id_illegal}, {31'd0, e_ill});
        check_eq("illegal_m0", {31'd0, id_illegal_0}, {31'd0, e_ill0});
        check_eq("hazard_stall", {31'd0, hazard_stall}, {31'd0, e_hz});
        check_eq("pc_sel", {30'd0, pc_sel}, {30'd0, e_pc});
        check_eq("flush", {31'd0, flush}, {31'd0, e_pc != 2'b00});
        @(posedge clk);
        #1;
        if (!stl) begin
            exp_wb = exp_ma;
            exp_ma = exp_ex;
            exp_ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        end
        check_eq("ex_alu_ctl", {27'd0, ex_alu_ctl}, {27'd0, exp_ex.alu});
        check_eq("ex_ab_sel", {30'd0, ex_A_sel, ex_B_sel}, {30'd0, exp_ex.a, exp_ex.b});
        check_eq("ma_din_sel", {30'd0, ma_din_sel}, {30'd0, exp_ma.din});
        check_eq("ma_dm_ctl", {28'd0, ma_dm_ctl}, {28'd0, exp_ma.dm});
        check_eq("ma_trim_ctl", {29'd0, ma_trim_ctl}, {29'd0, exp_ma.trim});
        check_eq("wb_reg_wrt", {31'd0, wb_reg_wrt}, {31'd0, exp_wb.wrt});
        check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, exp_wb.rd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'h0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    localparam logic [31:0] IAdd3  = 32'h002081B3, ILw5  = 32'h0000A283, IAdd6  = 32'h00228333;
    localparam logic [31:0] ILw0   = 32'h0000A003, IAdd0 = 32'h00200333, IBeq   = 32'h00208463;
    localparam logic [31:0] IAddi4 = 32'h00508213, IJalr = 32'h000100E7, ISrai  = 32'h4030D393;
    localparam logic [31:0] ISltiu = 32'h0010B413, ISw   = 32'h0020A223, ILui   = 32'h123454B7;
    localparam logic [31:0] ILbu   = 32'h0000C503, IMul  = 32'h022081B3, IBad   = 32'hFFFFFFFF;

    exp_t r_add3, r_lw5, r_add6, r_lw0, r_beq, r_addi4, r_jalr, r_srai;
    exp_t r_sltiu, r_sw, r_lui, r_lbu, r_mul;
    localparam exp_t Bub = '0;

    initial begin
        //          alu       a     b     din    dm       trim    wrt   rd
        r_add3  = '{5'b00001, 1'b1, 1'b0, 2'b10, 4'b0000, 3'b000, 1'b1, 5'd3};
        r_lw5   = '{5'b00001, 1'b1, 1'b1, 2'b11, 4'b0000, 3'b000, 1'b1, 5'd5};
        r_add6  = '{5'b00001, 1'b1, 1'b0, 2'b10, 4'b0000, 3'b000, 1'b1, 5'd6};
        r_lw0   = '{5'b00001, 1'b1, 1'b1, 2'b11, 4'b0000, 3'b000, 1'b0, 5'd0};
        r_beq   = '{5'b01011, 1'b1, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0, 5'd0};
        r_addi4 = '{5'b00001, 1'b1, 1'b1, 2'b10, 4'b0000, 3'b000, 1'b1, 5'd4};
        r_jalr  = '{5'b00001, 1'b1, 1'b1, 2'b01, 4'b0000, 3'b000, 1'b1, 5'd1};
        r_srai  = '{5'b01010, 1'b1, 1'b1, 2'b10, 4'b0000, 3'b000, 1'b1, 5'd7};
        r_sltiu = '{5'b00011, 1'b1, 1'b1, 2'b10, 4'b0000, 3'b000, 1'b1, 5'd8};
        r_sw    = '{5'b00001, 1'b1, 1'b1, 2'b00, 4'b1111, 3'b000, 1'b0, 5'd0};
        r_lui   = '{5'b10001, 1'b0, 1'b1, 2'b10, 4'b0000, 3'b000, 1'b1, 5'd9};
        r_lbu   = '{5'b10010, 1'b1, 1'b1, 2'b11, 4'b0000, 3'b011, 1'b1, 5'd10};
        r_mul   = '{5'b10011, 1'b1, 1'b0, 2'b10, 4'b0000, 3'b000, 1'b1, 5'd3};
        exp_ex = '0; exp_ma = '0; exp_wb = '0;

        rst = 1'b1; id_inst = '0; id_valid = 1'b0; stall_ext = 1'b0; ex_b_cmp = 1'b0;
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic ADD through all stages
        cyc(IAdd3, 1, 0, 0, r_add3, 4'b0000, 0, 0, 0, 2'b00);
        idle(3);
        // Load-use: one stall cycle, bubble, then ADD; rd=x0 load never stalls
        cyc(ILw5,  1, 0, 0, r_lw5,  4'b0001, 0, 0, 0, 2'b00);
        cyc(IAdd6, 1, 0, 0, Bub,    4'b0000, 0, 0, 1, 2'b00);
        cyc(IAdd6, 1, 0, 0, r_add6, 4'b0000, 0, 0, 0, 2'b00);
        cyc(ILw0,  1, 0, 0, r_lw0,  4'b0001, 0, 0, 0, 2'b00);
        cyc(IAdd0, 1, 0, 0, r_add6, 4'b0000, 0, 0, 0, 2'b00);
        idle(1);
        // Branch taken flushes the next instruction; not taken lets it through
        cyc(IBeq,   1, 0, 0, r_beq,   4'b0100, 0, 0, 0, 2'b00);
        cyc(IAddi4, 1, 0, 1, Bub,     4'b0001, 0, 0, 0, 2'b01);
        idle(1);
        cyc(IBeq,   1, 0, 0, r_beq,   4'b0100, 0, 0, 0, 2'b00);
        cyc(IAddi4, 1, 0, 0, r_addi4, 4'b0001, 0, 0, 0, 2'b00);
        // JALR in EX held by an external stall: no redirect until the stall releases
        cyc(IJalr, 1, 0, 0, r_jalr, 4'b0001, 0, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) cyc(ISrai, 1, 1, 0, Bub, 4'b0010, 0, 0, 0, 2'b00);
        cyc(ISrai, 1, 0, 0, Bub,    4'b0010, 0, 0, 0, 2'b10);
        cyc(ISrai, 1, 0, 0, r_srai, 4'b0010, 0, 0, 0, 2'b00);
        // Assorted decode, M extension and an illegal opcode
        cyc(ISltiu, 1, 0, 0, r_sltiu, 4'b1001, 0, 0, 0, 2'b00);
        cyc(ISw,    1, 0, 0, r_sw,    4'b0011, 0, 0, 0, 2'b00);
        cyc(ILui,   1, 0, 0, r_lui,   4'b0101, 0, 0, 0, 2'b00);
        cyc(ILbu,   1, 0, 0, r_lbu,   4'b0001, 0, 0, 0, 2'b00);
        cyc(IMul,   1, 0, 0, r_mul,   4'b0000, 0, 1, 0, 2'b00);
        cyc(IBad,   1, 0, 0, Bub,     4'b0000, 1, 1, 0, 2'b00);
        idle(3);
        // Reset with three instructions in flight
        cyc(IAddi4, 1, 0, 0, r_addi4, 4'b0001, 0, 0, 0, 2'b00);
        cyc(ILui,   1, 0, 0, r_lui,   4'b0101, 0, 0, 0, 2'b00);
        cyc(IAdd3,  1, 0, 0, r_add3,  4'b0000, 0, 0, 0, 2'b00);
        rst = 1'b1; id_valid = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        exp_ex = '0; exp_ma = '0; exp_wb = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(IAdd3, 1, 0, 0, r_add3, 4'b0000, 0, 0, 0, 2'b00);
        idle(3);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
